// File: rtl/ifft_pkg.sv
// Shared constants, types and helpers for the 16-point inverse FFT controller.
package ifft_pkg;

  localparam int FFT_POINTS  = 16;
  localparam int IN_WIDTH    = 32;
  localparam int DATA_WIDTH  = 24;
  localparam int TW_WIDTH    = 18;
  localparam int LOG2_POINTS = $clog2(FFT_POINTS);

  // One complex work word; both halves are full-width signed values.
  typedef struct packed {
    logic signed [IN_WIDTH-1:0] re;
    logic signed [IN_WIDTH-1:0] im;
  } complex_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BFLY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Twiddles in Q2.16: cos(2*pi*t/16) and sin(2*pi*t/16), positive exponent.
  localparam logic signed [TW_WIDTH-1:0] TW_COS [0:FFT_POINTS/2-1] = '{
    18'sd65536,  18'sd60547,  18'sd46341,  18'sd25080,
    18'sd0,     -18'sd25080, -18'sd46341, -18'sd60547
  };
  localparam logic signed [TW_WIDTH-1:0] TW_SIN [0:FFT_POINTS/2-1] = '{
    18'sd0,      18'sd25080,  18'sd46341,  18'sd60547,
    18'sd65536,  18'sd60547,  18'sd46341,  18'sd25080
  };

  // Reverse the LOG2_POINTS-bit index.
  function automatic logic [LOG2_POINTS-1:0] bitrev(input logic [LOG2_POINTS-1:0] v);
    logic [LOG2_POINTS-1:0] r;
    for (int i = 0; i < LOG2_POINTS; i++) begin
      r[i] = v[LOG2_POINTS-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ifft_butterfly.sv
// Combinational radix-2 DIT butterfly with built-in halving for 1/N scaling.
module ifft_butterfly
  import ifft_pkg::*;
(
  input  complex_t                    a_i,
  input  complex_t                    b_i,
  input  logic signed [TW_WIDTH-1:0]  w_re_i,
  input  logic signed [TW_WIDTH-1:0]  w_im_i,
  output complex_t                    top_o,
  output complex_t                    bot_o
);

  logic signed [49:0] rr, ii, ri, ir;
  logic signed [50:0] pr_full, pi_full;
  logic signed [34:0] p_re, p_im;
  logic signed [35:0] sum_re, sum_im, dif_re, dif_im;

  // p = b*W truncated to Q0, then (a +/- p)/2 with floor rounding.
  always_comb begin
    rr      = 50'(b_i.re) * 50'(w_re_i);
    ii      = 50'(b_i.im) * 50'(w_im_i);
    ri      = 50'(b_i.re) * 50'(w_im_i);
    ir      = 50'(b_i.im) * 50'(w_re_i);
    pr_full = 51'(rr) - 51'(ii);
    pi_full = 51'(ri) + 51'(ir);
    p_re    = 35'(pr_full >>> 16);
    p_im    = 35'(pi_full >>> 16);
    sum_re  = 36'(a_i.re) + 36'(p_re);
    sum_im  = 36'(a_i.im) + 36'(p_im);
    dif_re  = 36'(a_i.re) - 36'(p_re);
    dif_im  = 36'(a_i.im) - 36'(p_im);
    top_o.re = 32'(sum_re >>> 1);
    top_o.im = 32'(sum_im >>> 1);
    bot_o.re = 32'(dif_re >>> 1);
    bot_o.im = 32'(dif_im >>> 1);
  end

endmodule

// File: rtl/ifft_controller.sv
// Iterative 16-point inverse FFT: one butterfly per clock on an in-place
// register file, saturated 24-bit real output.
module ifft_controller
  import ifft_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_ifft,
  input  logic signed [IN_WIDTH-1:0]   in_data_real [0:FFT_POINTS-1],
  input  logic signed [IN_WIDTH-1:0]   in_data_imag [0:FFT_POINTS-1],
  output logic signed [DATA_WIDTH-1:0] out_data     [0:FFT_POINTS-1],
  output logic                         ifft_data_valid,
  output logic                         ifft_in_prog
);

  state_e                      state_q, state_d;
  logic [1:0]                  stage_q, stage_d;
  logic [2:0]                  idx_q, idx_d;
  complex_t                    work_q [0:FFT_POINTS-1];
  complex_t                    work_d [0:FFT_POINTS-1];
  logic signed [DATA_WIDTH-1:0] out_q [0:FFT_POINTS-1];
  logic signed [DATA_WIDTH-1:0] out_d [0:FFT_POINTS-1];
  logic                        valid_q, valid_d;
  logic                        prog_q, prog_d;

  logic [2:0]                  low_mask;
  logic [3:0]                  span;
  logic [3:0]                  a_idx, b_idx;
  logic [2:0]                  tw_idx;
  complex_t                    bf_top, bf_bot;

  // Clamp a work word to the signed 24-bit output range.
  function automatic logic signed [DATA_WIDTH-1:0] sat24(input logic signed [IN_WIDTH-1:0] v);
    if (v > 32'sh007F_FFFF)       return 24'sh7F_FFFF;
    else if (v < -32'sh0080_0000) return -24'sh80_0000;
    else                          return 24'(v);
  endfunction

  // Butterfly addressing: a = idx + (idx with the low stage bits cleared).
  always_comb begin
    span     = 4'd1 << stage_q;
    low_mask = 3'(span - 4'd1);
    a_idx    = {1'b0, idx_q} + {1'b0, idx_q & ~low_mask};
    b_idx    = a_idx + span;
    tw_idx   = (idx_q & low_mask) << (2'd3 - stage_q);
  end

  ifft_butterfly u_bfly (
    .a_i    (work_q[a_idx]),
    .b_i    (work_q[b_idx]),
    .w_re_i (TW_COS[tw_idx]),
    .w_im_i (TW_SIN[tw_idx]),
    .top_o  (bf_top),
    .bot_o  (bf_bot)
  );

  // Next-state, counters, register file and output updates.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    idx_d   = idx_q;
    work_d  = work_q;
    out_d   = out_q;
    valid_d = 1'b0;
    prog_d  = prog_q;
    case (state_q)
      IDLE: begin
        if (start_ifft) begin
          for (int i = 0; i < FFT_POINTS; i++) begin
            work_d[bitrev(4'(i))].re = in_data_real[i];
            work_d[bitrev(4'(i))].im = in_data_imag[i];
          end
          stage_d = 2'd0;
          idx_d   = 3'd0;
          prog_d  = 1'b1;
          state_d = BFLY;
        end
      end
      BFLY: begin
        work_d[a_idx] = bf_top;
        work_d[b_idx] = bf_bot;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          stage_d = stage_q + 2'd1;
          if (stage_q == 2'd3) state_d = DONE;
        end
      end
      DONE: begin
        for (int i = 0; i < FFT_POINTS; i++) begin
          out_d[i] = sat24(work_q[i].re);
        end
        valid_d = 1'b1;
        prog_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and data registers; reset discards any in-flight transform.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      stage_q <= 2'd0;
      idx_q   <= 3'd0;
      work_q  <= '{default: '0};
      out_q   <= '{default: '0};
      valid_q <= 1'b0;
      prog_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      prog_q  <= prog_d;
    end
  end

  assign out_data        = out_q;
  assign ifft_data_valid = valid_q;
  assign ifft_in_prog    = prog_q;

endmodule

// File: tb/tb_ifft_controller.sv
// Scoreboard bench for ifft_controller: stimulus pushes expected spectra
// results, a monitor pops and compares on every valid pulse.
module tb_ifft_controller;
  import ifft_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_ifft;
  logic signed [IN_WIDTH-1:0]   in_re  [0:FFT_POINTS-1];
  logic signed [IN_WIDTH-1:0]   in_im  [0:FFT_POINTS-1];
  logic signed [DATA_WIDTH-1:0] out_data [0:FFT_POINTS-1];
  logic valid;
  logic prog;

  ifft_controller dut (
    .clk             (clk),
    .reset           (reset),
    .start_ifft      (start_ifft),
    .in_data_real    (in_re),
    .in_data_imag    (in_im),
    .out_data        (out_data),
    .ifft_data_valid (valid),
    .ifft_in_prog    (prog)
  );

  int total = 0;
  int bad   = 0;
  logic [FFT_POINTS*DATA_WIDTH-1:0] exp_q [$];
  int tol_q [$];

  task automatic check(input string nm, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < FFT_POINTS; i++) begin
      in_re[i] = '0;
      in_im[i] = '0;
    end
  endtask

  task automatic push_const(input logic [DATA_WIDTH-1:0] v, input int tol);
    logic [FFT_POINTS*DATA_WIDTH-1:0] e;
    for (int i = 0; i < FFT_POINTS; i++) e[i*DATA_WIDTH +: DATA_WIDTH] = v;
    exp_q.push_back(e);
    tol_q.push_back(tol);
  endtask

  // Pulse start, follow handshake timing; optionally scramble inputs after
  // capture and re-pulse start mid-transform.
  task automatic run_one(input string nm, input bit stress);
    int first;
    first = -1;
    @(negedge clk) start_ifft = 1'b1;
    @(posedge clk) #1 start_ifft = 1'b0;
    check({nm, "_prog_rise"}, int'(prog), 1);
    if (stress) begin
      for (int i = 0; i < FFT_POINTS; i++) begin
        in_re[i] = $urandom;
        in_im[i] = $urandom;
      end
    end
    for (int n = 1; n <= 45; n++) begin
      if (stress && n == 10) start_ifft = 1'b1;
      @(posedge clk) #1;
      start_ifft = 1'b0;
      if (valid === 1'b1 && first < 0) first = n;
      if (n == 32) check({nm, "_prog_k32"}, int'(prog), 1);
      if (n == 33) begin
        check({nm, "_prog_fall"}, int'(prog), 0);
        check({nm, "_valid_k33"}, int'(valid), 1);
      end
      if (n == 34) check({nm, "_valid_one_cycle"}, int'(valid), 0);
    end
    check({nm, "_latency"}, first, 33);
  endtask

  // Monitor: compare every presented result against the scoreboard head.
  initial begin
    logic [FFT_POINTS*DATA_WIDTH-1:0] e;
    int t, d;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got a valid pulse, expected none at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          t = tol_q.pop_front();
          for (int i = 0; i < FFT_POINTS; i++) begin
            total++;
            d = int'(out_data[i]) - int'($signed(e[i*DATA_WIDTH +: DATA_WIDTH]));
            if (d > t || d < -t) begin
              bad++;
              $display("FAIL out_data[%0d]: got %0d, expected %0d (tol %0d)", i,
                       int'(out_data[i]), int'($signed(e[i*DATA_WIDTH +: DATA_WIDTH])), t);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FFT_POINTS*DATA_WIDTH-1:0] e;
    int cnt, last;
    reset = 1'b1;
    start_ifft = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", int'(valid), 0);
    check("reset_prog", int'(prog), 0);
    check("reset_out0", int'(out_data[0]), 0);
    check("reset_out15", int'(out_data[15]), 0);
    @(negedge clk) reset = 1'b0;

    // DC bin with input scrambling and ignored re-start
    clear_inputs();
    in_re[0] = 32'sh0100_0000;
    push_const(24'h10_0000, 0);
    run_one("dc", 1'b1);

    // Square wave
    clear_inputs();
    in_re[4]  = 32'sh0200_0000;
    in_im[4]  = -32'sh0200_0000;
    in_re[12] = 32'sh0200_0000;
    in_im[12] = 32'sh0200_0000;
    for (int i = 0; i < FFT_POINTS; i++)
      e[i*DATA_WIDTH +: DATA_WIDTH] = ((i % 4) < 2) ? 24'h40_0000 : 24'hC0_0000;
    exp_q.push_back(e);
    tol_q.push_back(4);
    run_one("square", 1'b0);

    // Saturation both directions
    clear_inputs();
    in_re[0] = 32'sh7FFF_FFFF;
    push_const(24'h7F_FFFF, 0);
    run_one("sat_pos", 1'b0);
    clear_inputs();
    in_re[0] = 32'sh8000_0000;
    push_const(24'h80_0000, 0);
    run_one("sat_neg", 1'b0);

    // Reset mid-transform
    clear_inputs();
    in_re[0] = 32'sh0100_0000;
    @(negedge clk) start_ifft = 1'b1;
    @(posedge clk) #1 start_ifft = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk) #1;
    check("midrst_prog", int'(prog), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_out0", int'(out_data[0]), 0);
    check("midrst_out7", int'(out_data[7]), 0);
    @(negedge clk) reset = 1'b0;
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk) #1;
      if (valid === 1'b1) cnt++;
    end
    check("midrst_no_valid", cnt, 0);
    push_const(24'h10_0000, 0);
    run_one("dc_after_rst", 1'b0);

    // Back-to-back with start held high
    for (int r = 0; r < 3; r++) push_const(24'h10_0000, 0);
    cnt = 0;
    last = -1;
    @(negedge clk) start_ifft = 1'b1;
    for (int n = 1; n <= 150; n++) begin
      @(posedge clk) #1;
      if (valid === 1'b1) begin
        if (cnt > 0) check("b2b_spacing", n - last, 34);
        last = n;
        cnt++;
        if (cnt == 3) begin
          start_ifft = 1'b0;
          break;
        end
      end
    end
    start_ifft = 1'b0;
    check("b2b_count", cnt, 3);
    repeat (40) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifft_controller.md
Name: ifft_controller

Overview:
- Inverse of fft_controller: takes a 16-point complex spectrum as parallel 32-bit real/imag arrays and returns the 24-bit time-domain real signal.
- Sits on the back end of the convolution path (FFT -> spectral multiply -> this block).
- Iterative radix-2 decimation-in-time, one butterfly per clock, in-place register file, 1/N scaling built in.

Parameters:
- FFT_POINTS, 16, transform length; fixed power of two (the stage count derives from it).
- IN_WIDTH, 32, signed width of the input real/imag words and of the internal work registers.
- DATA_WIDTH, 24, signed width of the time-domain output.
- TW_WIDTH, 18, signed twiddle width, Q2.16 format (1.0 = 0x10000 exactly).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- start_ifft  in  1  request; sampled only in IDLE.
- in_data_real  in  [IN_WIDTH-1:0] x [0:FFT_POINTS-1]  spectrum real parts, signed.
- in_data_imag  in  [IN_WIDTH-1:0] x [0:FFT_POINTS-1]  spectrum imaginary parts, signed.
- out_data  out  [DATA_WIDTH-1:0] x [0:FFT_POINTS-1]  time-domain real result, signed, saturated.
- ifft_data_valid  out  1  one-cycle pulse when out_data is updated.
- ifft_in_prog  out  1  high while a transform is running.

Behaviour:
- Reset: one clock and a synchronous, active-high reset. With reset high at an edge: state=IDLE, out_data all 0, ifft_data_valid=0, ifft_in_prog=0, work registers 0, counters 0. Reset takes priority over every other event, including mid-transform (in-flight work is discarded, no valid pulse).
- FSM states: IDLE, BFLY, DONE.
- IDLE -> BFLY, at edge k with start_ifft=1:
  - Capture inputs into the work registers in bit-reversed index order (work[bitrev4(i)] = in[i]).
  - Set ifft_in_prog=1, stage=0, idx=0.
  - Inputs are not sampled after edge k and may change freely.
- BFLY: one butterfly per edge, edges k+1..k+32 (4 stages x 8 butterflies).
  - span = 2^stage.
  - a = (idx/span)*2*span + (idx mod span); b = a + span.
  - Twiddle index t = (idx mod span)*(8/span). Twiddle W = cos(2*pi*t/16) + j*sin(2*pi*t/16), a positive exponent (inverse transform).
  - p = work[b]*W: a 50-bit product, arithmetic shift right by 16 (truncate toward -inf).
  - Write work[a] = (work[a]+p)>>>1 and work[b] = (work[a]-p)>>>1. Intermediate sums are 33 bits; the >>>1 restores 32 bits. The total scaling over 4 stages is 1/16.
  - idx wraps 7->0 with stage+1. After the butterfly at stage=3, idx=7 (edge k+32), go to DONE.
- DONE, at edge k+33:
  - out_data[i] = sat24(work[i].real). Values above 0x7FFFFF clamp to 0x7FFFFF; values below -0x800000 clamp to 0x800000.
  - The imaginary part is discarded.
  - ifft_data_valid=1 for exactly the cycle after edge k+33; ifft_in_prog=0; go to IDLE.
- Latency: start edge k to valid is 33 edges. Throughput is one transform per 34 cycles. out_data holds its value until the next DONE or a reset.
- start_ifft while in BFLY/DONE is ignored (not queued). start_ifft held high in IDLE right after DONE starts a new transform at the next edge.
- Saturation never wraps. Truncation error is at most 4 LSB at the output due to per-stage shifts.

Decomposition:
- Package ifft_pkg holds:
  - FFT_POINTS, IN_WIDTH, DATA_WIDTH, TW_WIDTH, LOG2_POINTS.
  - The complex_t struct (signed real, signed imag, IN_WIDTH).
  - The state enum {IDLE, BFLY, DONE}.
  - Twiddle constant arrays TW_COS[0:7] and TW_SIN[0:7] in Q2.16 (e.g. k=2: 46341/46341).
  - A bitrev function.
- One combinational sub-module, ifft_butterfly: inputs a, b, w; outputs the scaled top and bottom results. The controller owns the FSM, counters and register file.

Test Plan:
- DC bin: X[0]=0x1000000+j0, all other bins 0, pulse start_ifft -> after 33 edges valid pulses once, out_data[0..15] all = 0x100000 exactly.
- Square wave (inverse of the fft_controller test vector):
  - Stimulus: X[4]=0x2000000-j0x2000000, X[12]=0x2000000+j0x2000000, other bins 0.
  - Response: out_data = 0x400000,0x400000,0xC00000,0xC00000 repeating, each within +-4 LSB.
- Saturation: X[0]=0x7FFFFFFF, other bins 0 -> all outputs 0x7FFFFF. With X[0]=0x80000000 -> all outputs 0x800000.
- Handshake timing:
  - ifft_in_prog rises at edge k and falls at edge k+33; valid is high exactly 1 cycle.
  - start_ifft re-pulsed at k+10 -> ignored, no second valid.
  - in_data changed at k+1 -> result unaffected.
- Reset mid-operation: assert reset at edge k+15 -> no valid pulse; out_data = 0; ifft_in_prog = 0. A following start gives correct DC result.
- Back-to-back: start_ifft held high continuously with the DC vector -> valid every 34 cycles, each result 0x100000.
